// File: rtl/icache_loader_pkg.sv
// ----------------------------------------------------------------------------
// icache_loader_pkg
// Shared definitions for the instruction-cache program loader: the loader
// state encoding and the byte-stream framing constants.
// ----------------------------------------------------------------------------
package icache_loader_pkg;

    // Stream framing: a little-endian 16-bit word count, then 4 bytes per word.
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

endpackage : icache_loader_pkg

// File: rtl/icache_loader_byte_packer.sv
// ----------------------------------------------------------------------------
// icache_loader_byte_packer
// Assembles consecutive stream bytes into one instruction word, least
// significant byte first.
//
// Ports
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   clear_i     restart assembly at lane 0 (start of a new load)
//   load_i      a byte transfers this cycle
//   byte_i      stream byte
//   word_o      assembled word including the byte currently on byte_i, so
//               the parent can capture a complete word on the 4th transfer
//   word_full_o the next transfer completes the word (lane index is 3)
// ----------------------------------------------------------------------------
module icache_loader_byte_packer
    import icache_loader_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        load_i,
    input  logic [7:0]                  byte_i,
    output logic [8*BYTES_PER_WORD-1:0] word_o,
    output logic                        word_full_o
);

    logic [8*BYTES_PER_WORD-1:0] word_q;
    logic [IDX_W-1:0]            idx_q;

    // Lane insert is combinational so the completed word is visible in the
    // same cycle the last byte arrives.
    always_comb begin
        word_o                = word_q;
        word_o[8*idx_q +: 8]  = byte_i;
    end

    assign word_full_o = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (clear_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            word_q <= word_o;
            // Wraps 3 -> 0 after the 4th byte, ready for the next word.
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

endmodule : icache_loader_byte_packer

// File: rtl/icache_loader.sv
// ----------------------------------------------------------------------------
// icache_loader
// Loads a program from a byte stream into the instruction cache write port
// and keeps the core in reset until the whole program has been written.
// Stream: word count N (16-bit, LE), then N words, each LSB first.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            one-cycle load request (honoured in IDLE/DONE/ERR only)
//   byte_valid_i       source presents byte_data_i
//   byte_data_i        stream byte
//   byte_ready_o       loader accepts a byte this cycle (depends on state only)
//   wren_o             icache write enable, one cycle per word
//   wraddr_o, wrdata_o icache word address/data; hold last value between writes
//   core_rst_no        core reset, active-low; released only after a good load
//   busy_o             a load is in progress
//   done_o             the last load completed
//   err_o              the last header carried an illegal word count
// ----------------------------------------------------------------------------
module icache_loader
    import icache_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              wren_o,
    output logic [ADDR_W-1:0] wraddr_o,
    output logic [DATA_W-1:0] wrdata_o,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    state_t              state_q, state_d;
    logic [15:0]         len_q;
    logic [ADDR_W-1:0]   count_q;
    logic [ADDR_W-1:0]   wraddr_q;
    logic [DATA_W-1:0]   wrdata_q;

    logic                accepting;
    logic                xfer;
    logic [15:0]         n_hdr;
    logic                hdr_bad;
    logic                last_word;
    logic                restart;
    logic [DATA_W-1:0]   packed_word;
    logic                word_full;

    // Ready is decoded from the state register only, never from byte_valid_i.
    assign accepting    = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    assign byte_ready_o = accepting;
    assign xfer         = byte_valid_i && accepting;

    // Full count as it will be once the high header byte lands.
    assign n_hdr     = {byte_data_i, len_q[7:0]};
    assign hdr_bad   = (n_hdr == 16'd0) || (n_hdr > 16'(MAX_WORDS));
    // len_q >= 1 here, so N-1 never underflows; counter stops at N-1 and
    // therefore never wraps, even for N == 2**ADDR_W.
    assign last_word = (16'(count_q) == (len_q - 16'd1));

    assign restart = start_i &&
                     ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

    icache_loader_byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (restart),
        .load_i      (xfer && (state_q == DATA)),
        .byte_i      (byte_data_i),
        .word_o      (packed_word),
        .word_full_o (word_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every output and next-state value gets a default before the case
    // so no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        wren_o      = 1'b0;
        core_rst_no = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = HDR0;
            end
            HDR0: begin
                busy_o = 1'b1;
                if (xfer) state_d = HDR1;
            end
            HDR1: begin
                busy_o = 1'b1;
                if (xfer) state_d = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                busy_o = 1'b1;
                if (xfer && word_full) state_d = WRITE;
            end
            WRITE: begin
                busy_o  = 1'b1;
                wren_o  = 1'b1;
                state_d = last_word ? DONE : DATA;
            end
            DONE: begin
                // Leaving DONE drops core_rst_no on the very next cycle.
                core_rst_no = 1'b1;
                done_o      = 1'b1;
                if (start_i) state_d = HDR0;
            end
            ERR: begin
                err_o = 1'b1;
                if (start_i) state_d = HDR0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/data are captured as the word completes so they stay stable
    // through WRITE and keep their value afterwards, while the packer is
    // already collecting the next word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q    <= '0;
            count_q  <= '0;
            wraddr_q <= '0;
            wrdata_q <= '0;
        end else begin
            if (state_q == HDR0 && xfer) begin
                len_q[7:0] <= byte_data_i;
            end
            if (state_q == HDR1 && xfer) begin
                len_q[15:8] <= byte_data_i;
                count_q     <= '0;
            end
            if (state_q == DATA && xfer && word_full) begin
                wraddr_q <= count_q;
                wrdata_q <= packed_word;
            end
            if (state_q == WRITE && !last_word) begin
                count_q <= count_q + ADDR_W'(1);
            end
        end
    end

    assign wraddr_o = wraddr_q;
    assign wrdata_o = wrdata_q;

endmodule : icache_loader

// File: tb/tb_icache_loader.sv
// ----------------------------------------------------------------------------
// tb_icache_loader
// Scoreboard bench: each word is pushed as expected {addr,data} when its
// bytes are driven, and popped/compared whenever wren_o is seen.
// ----------------------------------------------------------------------------
module tb_icache_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        wren_o;
    logic [9:0]  wraddr_o;
    logic [31:0] wrdata_o;
    logic        core_rst_no;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    icache_loader dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .wren_o       (wren_o),
        .wraddr_o     (wraddr_o),
        .wrdata_o     (wrdata_o),
        .core_rst_no  (core_rst_no),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Write monitor / scoreboard consumer.
    logic prev_wren = 1'b0;
    always @(negedge clk_i) begin
        wr_t e;
        if (rst_ni && wren_o) begin
            check("wr_single_cycle", 32'(prev_wren), 32'd0);
            check("wr_ready_low", 32'(byte_ready_o), 32'd0);
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(wraddr_o), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wraddr_o), 32'(e.addr));
                check("wr_data", wrdata_o, e.data);
            end
        end
        prev_wren = rst_ni && wren_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Present one byte until it is accepted (bounded); returns 1 ns after the
    // accepting clock edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            ok = byte_ready_o;
            @(posedge clk_i);
            #1;
            if (ok) break;
        end
        byte_valid_i = 1'b0;
        if (!ok) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    // mode 0: valid held high; mode 1: valid toggles 1/0; mode 2: start_i
    // held high while byte 2 of the word is offered. gap adds 10 idle cycles
    // after byte 1.
    task automatic send_word(input logic [9:0] addr, input logic [31:0] w,
                             input int mode, input bit gap);
        exp_q.push_back('{addr: addr, data: w});
        for (int b = 0; b < 4; b++) begin
            if (mode == 2 && b == 2) start_i = 1'b1;
            send_byte(w[8*b +: 8]);
            start_i = 1'b0;
            if (mode == 1) tick();
            if (gap && b == 1) repeat (10) tick();
        end
    endtask

    task automatic wait_end();
        bit seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (done_o || err_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_wren"},  32'(wren_o),       32'd0);
        check({pfx, "_ready"}, 32'(byte_ready_o), 32'd0);
        check({pfx, "_core"},  32'(core_rst_no),  32'd0);
        check({pfx, "_busy"},  32'(busy_o),       32'd0);
        check({pfx, "_done"},  32'(done_o),       32'd0);
        check({pfx, "_err"},   32'(err_o),        32'd0);
        check({pfx, "_addr"},  32'(wraddr_o),     32'd0);
        check({pfx, "_data"},  wrdata_o,          32'd0);
    endtask

    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (5) tick();
        check_quiet("idle");

        // Two-word program, valid held high; check latency of done/core release.
        pulse_start();
        check("start_busy", 32'(busy_o), 32'd1);
        check("start_ready", 32'(byte_ready_o), 32'd1);
        send_header(16'd2);
        send_word(10'd0, 32'h0050_0513, 0, 1'b0);
        send_word(10'd1, 32'h0070_0593, 0, 1'b0);
        @(negedge clk_i);
        check("t1_wren", 32'(wren_o), 32'd1);
        check("t1_done", 32'(done_o), 32'd0);
        check("t1_core", 32'(core_rst_no), 32'd0);
        @(negedge clk_i);
        check("t2_done", 32'(done_o), 32'd1);
        check("t2_core", 32'(core_rst_no), 32'd1);
        check("t2_busy", 32'(busy_o), 32'd0);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Same program, toggling valid and a 10-cycle mid-word gap.
        pulse_start();
        check("restart_core", 32'(core_rst_no), 32'd0);
        check("restart_done", 32'(done_o), 32'd0);
        send_header(16'd2);
        send_word(10'd0, 32'h0050_0513, 1, 1'b1);
        send_word(10'd1, 32'h0070_0593, 1, 1'b0);
        wait_end();
        check("toggle_done", 32'(done_o), 32'd1);
        check("toggle_sb_empty", 32'(exp_q.size()), 32'd0);

        // start_i during DATA must not disturb the load.
        pulse_start();
        send_header(16'd3);
        for (int i = 0; i < 3; i++) send_word(10'(i), $urandom, 2, 1'b0);
        wait_end();
        check("midstart_done", 32'(done_o), 32'd1);
        check("midstart_addr", 32'(wraddr_o), 32'd2);

        // N = 0 -> ERR; bytes offered in ERR are not accepted.
        pulse_start();
        send_header(16'd0);
        @(negedge clk_i);
        check("n0_err", 32'(err_o), 32'd1);
        check("n0_core", 32'(core_rst_no), 32'd0);
        check("n0_busy", 32'(busy_o), 32'd0);
        byte_valid_i = 1'b1;
        repeat (3) tick();
        check("n0_ready", 32'(byte_ready_o), 32'd0);
        byte_valid_i = 1'b0;
        pulse_start();
        send_header(16'd1);
        send_word(10'd0, 32'hDEAD_BEEF, 0, 1'b0);
        wait_end();
        check("after_err_done", 32'(done_o), 32'd1);
        check("after_err_err", 32'(err_o), 32'd0);

        // N = 1025 -> ERR.
        pulse_start();
        send_header(16'h0401);
        @(negedge clk_i);
        check("n1025_err", 32'(err_o), 32'd1);
        check("n1025_core", 32'(core_rst_no), 32'd0);

        // N = 1024 -> full cache, last write at 1023.
        pulse_start();
        send_header(16'h0400);
        for (int i = 0; i < 1024; i++) send_word(10'(i), $urandom, 0, 1'b0);
        wait_end();
        check("n1024_done", 32'(done_o), 32'd1);
        check("n1024_err", 32'(err_o), 32'd0);
        check("n1024_last_addr", 32'(wraddr_o), 32'd1023);
        check("n1024_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-load after 3 words and 2 bytes of the 4th.
        pulse_start();
        send_header(16'd5);
        for (int i = 0; i < 3; i++) send_word(10'(i), $urandom, 0, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        #2 rst_ni = 1'b0;
        #1;
        check_quiet("abort");
        check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        pulse_start();
        send_header(16'd1);
        send_word(10'd0, 32'h1234_5678, 0, 1'b0);
        wait_end();
        check("reload_done", 32'(done_o), 32'd1);
        check("reload_addr", 32'(wraddr_o), 32'd0);
        check("reload_data", wrdata_o, 32'h1234_5678);

        repeat (3) tick();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_icache_loader
